// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the RAM port arbiter
package mem_port_arbiter_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    // Arbiter FSM states
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Requester ids; also the bit positions inside a one-hot grant vector
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    // One-hot grant vector for a requester id
    function automatic logic [1:0] id_onehot(input logic id);
        logic [1:0] oh;
        oh     = 2'b00;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/LSU request ports plus RAM pins of the arbiter
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    // Fetch port (read only)
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // Load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // RAM pins
    logic          mem_wena;
    logic          mem_rena;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    // Arbiter view
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_wena, mem_rena, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    // Requester + RAM view
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_wena, mem_rena, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way arbiter producing a one-hot grant
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req_i,
    input  logic       d_req_i,
    input  logic       last_win_i,
    output logic [1:0] gnt_o
);

    // On contention the port that did not win last time is chosen
    always_comb begin
        gnt_o = 2'b00;
        if (if_req_i && d_req_i) begin
            if (last_win_i == REQ_IF) begin
                gnt_o = id_onehot(REQ_D);
            end else begin
                gnt_o = id_onehot(REQ_IF);
            end
        end else if (d_req_i) begin
            gnt_o = id_onehot(REQ_D);
        end else if (if_req_i) begin
            gnt_o = id_onehot(REQ_IF);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port RAM between fetch and LSU; MEMARB_RR_EN selects round-robin
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    state_e        state_q, state_d;

    logic          cmd_id_q, cmd_id_d;
    logic          cmd_we_q, cmd_we_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;

    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;

    logic [1:0]    pick_gnt;
    logic          last_win;
    logic          if_gnt, d_gnt;
    logic          mem_wena, mem_rena;

    mem_arb_pick u_pick (
        .if_req_i   (bus.if_req),
        .d_req_i    (bus.d_req),
        .last_win_i (last_win),
        .gnt_o      (pick_gnt)
    );

`ifdef MEMARB_RR_EN
    logic last_win_q, last_win_d;

    // Track the most recent winner of any grant, contended or not
    always_comb begin
        last_win_d = last_win_q;
        if (state_q == IDLE && pick_gnt != 2'b00) begin
            last_win_d = pick_gnt[REQ_D] ? REQ_D : REQ_IF;
        end
    end

    // Last-winner register starts at fetch so the first contention favours data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win_q <= REQ_IF;
        end else begin
            last_win_q <= last_win_d;
        end
    end

    assign last_win = last_win_q;
`else
    // Pinned to fetch so the picker always favours data on contention
    assign last_win = REQ_IF;
`endif

    // FSM next state, command capture, response update and RAM enables
    always_comb begin
        state_d     = state_q;
        cmd_id_d    = cmd_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_wena    = 1'b0;
        mem_rena    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_gnt != 2'b00) begin
                    if_gnt  = pick_gnt[REQ_IF];
                    d_gnt   = pick_gnt[REQ_D];
                    state_d = ACCESS;
                    if (pick_gnt[REQ_D]) begin
                        cmd_id_d    = REQ_D;
                        cmd_we_d    = bus.d_we;
                        cmd_addr_d  = bus.d_addr;
                        cmd_wdata_d = bus.d_wdata;
                    end else begin
                        // fetch is always a read and carries no data
                        cmd_id_d    = REQ_IF;
                        cmd_we_d    = 1'b0;
                        cmd_addr_d  = bus.if_addr;
                        cmd_wdata_d = '0;
                    end
                end
            end

            ACCESS: begin
                mem_wena = cmd_we_q;
                mem_rena = ~cmd_we_q;
                state_d  = IDLE;
                if (cmd_id_q == REQ_D) begin
                    d_rvalid_d = 1'b1;
                    // mem_rdata only looked at when the read enable is up
                    d_rdata_d  = cmd_we_q ? '0 : bus.mem_rdata;
                end else begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = bus.mem_rdata;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, command and response registers; reset drops any pending access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_id_q    <= REQ_IF;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    // Enables come from state_q, so an async reset kills mem_wena before the edge
    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_wena  = mem_wena;
    assign bus.mem_rena  = mem_rena;
    assign bus.mem_addr  = cmd_addr_q;
    assign bus.mem_wdata = cmd_wdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q == ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM: combinational read, write at the edge, address 0 writes discarded
    logic [31:0] ram [256];
    assign bus.mem_rdata = bus.mem_rena ? ram[bus.mem_addr[7:0]] : 32'hDEAD_BEEF;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i;
        ram[200] = 32'd999;
        ram[0]   = 32'h0BAD_0000;
        forever begin
            @(posedge clk);
            if (bus.mem_wena && bus.mem_addr != 32'd0) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    // Reference memory and expectation queues
    logic [31:0] ref_mem [256];
    typedef struct { int due; logic [31:0] data; } exp_t;
    exp_t if_q[$];
    exp_t d_q[$];

    // Requester intent
    logic        if_pend = 0, d_pend = 0, d_w = 0;
    logic [31:0] if_a = 0, d_a = 0, d_wd = 0;

    // Model of the arbiter's occupancy
    logic        acc_v = 0, acc_we = 0, last_d = 0;
    logic [31:0] acc_wd = 0, last_addr = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle: drive from intent, check RAM pins and grants, book expectations
    task automatic step();
        logic eg_if, eg_d;
        logic [31:0] v;
        bus.if_req  = if_pend;
        bus.if_addr = if_a;
        bus.d_req   = d_pend;
        bus.d_we    = d_w;
        bus.d_addr  = d_a;
        bus.d_wdata = d_wd;
        #1;
        chk1("busy", bus.busy, acc_v);
        chk1("mem_wena", bus.mem_wena, acc_v && acc_we);
        chk1("mem_rena", bus.mem_rena, acc_v && !acc_we);
        chk32("mem_addr", bus.mem_addr, last_addr);
        if (acc_v && acc_we) chk32("mem_wdata", bus.mem_wdata, acc_wd);
        eg_if = 1'b0;
        eg_d  = 1'b0;
        if (!acc_v) begin
            if (if_pend && d_pend) begin
`ifdef MEMARB_RR_EN
                if (last_d) eg_if = 1'b1;
                else        eg_d  = 1'b1;
`else
                eg_d = 1'b1;
`endif
            end else begin
                eg_if = if_pend;
                eg_d  = d_pend;
            end
        end
        chk1("if_gnt", bus.if_gnt, eg_if);
        chk1("d_gnt", bus.d_gnt, eg_d);
        acc_v = 1'b0;
        if (eg_d) begin
            if (d_w) begin
                v = 32'd0;
                if (d_a != 32'd0) ref_mem[d_a[7:0]] = d_wd;
            end else begin
                v = ref_mem[d_a[7:0]];
            end
            d_q.push_back('{due: cyc + 2, data: v});
            acc_v = 1'b1; acc_we = d_w; acc_wd = d_wd; last_addr = d_a;
            d_pend = 1'b0; last_d = 1'b1;
        end
        if (eg_if) begin
            if_q.push_back('{due: cyc + 2, data: ref_mem[if_a[7:0]]});
            acc_v = 1'b1; acc_we = 1'b0; last_addr = if_a;
            if_pend = 1'b0; last_d = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle();
        for (int k = 0; k < 40 && (if_pend || d_pend); k++) step();
        if (if_pend || d_pend) begin
            n_cmp++; n_err++;
            $display("FAIL req_timeout: if_pend %b d_pend %b required both granted", if_pend, d_pend);
            if_pend = 1'b0; d_pend = 1'b0;
        end
        repeat (3) step();
    endtask

    // Monitor: pops the scoreboard whenever a response pulse shows up
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.if_rvalid) begin
                n_cmp++;
                if (if_q.size() == 0) begin
                    n_err++; $display("FAIL if_rvalid_unexpected: got pulse required none (cycle %0d)", cyc);
                end else begin
                    e = if_q.pop_front();
                    if (e.due != cyc || bus.if_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL if_resp: got %h at cycle %0d required %h at cycle %0d", bus.if_rdata, cyc, e.data, e.due);
                    end
                end
            end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
                n_cmp++; n_err++;
                e = if_q.pop_front();
                $display("FAIL if_rvalid_missing: got none required pulse at cycle %0d", e.due);
            end
            if (bus.d_rvalid) begin
                n_cmp++;
                if (d_q.size() == 0) begin
                    n_err++; $display("FAIL d_rvalid_unexpected: got pulse required none (cycle %0d)", cyc);
                end else begin
                    e = d_q.pop_front();
                    if (e.due != cyc || bus.d_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL d_resp: got %h at cycle %0d required %h at cycle %0d", bus.d_rdata, cyc, e.data, e.due);
                    end
                end
            end else if (d_q.size() > 0 && d_q[0].due <= cyc) begin
                n_cmp++; n_err++;
                e = d_q.pop_front();
                $display("FAIL d_rvalid_missing: got none required pulse at cycle %0d", e.due);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_wena"}, bus.mem_wena, 1'b0);
        chk1({tag, "_rena"}, bus.mem_rena, 1'b0);
        chk32({tag, "_addr"}, bus.mem_addr, 32'd0);
        chk32({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        chk32({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk32({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
        chk1({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
        chk1({tag, "_d_rvalid"}, bus.d_rvalid, 1'b0);
        chk1({tag, "_if_gnt"}, bus.if_gnt, 1'b0);
        chk1({tag, "_d_gnt"}, bus.d_gnt, 1'b0);
    endtask

    initial begin
        logic [31:0] old9;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + i;
        ref_mem[200] = 32'd999;
        ref_mem[0]   = 32'h0BAD_0000;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

        @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single fetch from 200
        if_pend = 1; if_a = 32'd200;
        run_until_idle();

        // store then load at 5
        d_pend = 1; d_w = 1; d_a = 32'd5; d_wd = 32'hA5A5_A5A5;
        run_until_idle();
        d_pend = 1; d_w = 0; d_a = 32'd5;
        run_until_idle();

        // store to address 0 is discarded by the RAM, load returns old value
        d_pend = 1; d_w = 1; d_a = 32'd0; d_wd = 32'd7;
        run_until_idle();
        d_pend = 1; d_w = 0; d_a = 32'd0;
        run_until_idle();

        // contention: both requesters keep asking
        if_pend = 1; if_a = 32'd3;
        d_pend = 1; d_w = 0; d_a = 32'd4;
        for (int k = 0; k < 8; k++) begin
            step();
`ifdef MEMARB_RR_EN
            if (!if_pend) begin if_pend = 1; if_a = 32'd10 + k; end
`endif
            if (!d_pend) begin d_pend = 1; d_w = 0; d_a = 32'd20 + k; end
        end
        run_until_idle();

        // reset in the middle of a store
        run_until_idle();
        old9 = ref_mem[9];
        d_pend = 1; d_w = 1; d_a = 32'd9; d_wd = 32'h1234_5678;
        step();
        chk1("rst_store_granted", d_pend, 1'b0);
        bus.d_req = 1'b0;
        d_pend = 1'b0;
        #1;
        chk1("rst_pre_wena", bus.mem_wena, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        d_q.delete();
        ref_mem[9] = old9;
        acc_v = 0; acc_we = 0; last_addr = 0; last_d = 0;
        @(negedge clk);
        chk32("rst_ram_unchanged", ram[9], old9);
        rst_n = 1'b1;
        d_pend = 1; d_w = 0; d_a = 32'd9;
        run_until_idle();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_a = 32'($urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_w = 1'($urandom_range(0, 1));
                d_a = 32'($urandom_range(0, 15)); d_wd = $urandom;
            end
            step();
        end
        run_until_idle();
        repeat (2) @(negedge clk);

        chk32("if_q_drained", 32'(if_q.size()), 32'd0);
        chk32("d_q_drained", 32'(d_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
